// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared definitions for the PIC interrupt acknowledge path.
// Contents: handshake state enum, trigger-mode constants, spurious level,
// level-to-one-hot helper.
package pic_pkg;

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LEVEL_W    = 3;
  localparam int unsigned VBASE_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK1  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_ACK2  = 3'd4
  } state_e;

  localparam logic EDGE_TRIGGERED  = 1'b0;
  localparam logic LEVEL_TRIGGERED = 1'b1;

  // Level reported when the request disappears before the first INTA.
  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  function automatic logic [NUM_LEVELS-1:0] level_onehot(input logic [LEVEL_W-1:0] lvl);
    return NUM_LEVELS'(1) << lvl;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Priority_Resolver: combinational lowest-set-index finder, IR0 highest.
// Ports: i_vec (8-bit vector), o_idx_c (index of lowest set bit, 0 if none),
//        o_valid_c (1 when any bit of i_vec is set).
module Priority_Resolver
  import pic_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] i_vec,
  output logic [LEVEL_W-1:0]    o_idx_c,
  output logic                  o_valid_c
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    for (int i = int'(NUM_LEVELS) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx_c   = LEVEL_W'(i);
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: raises INT for the highest-priority unmasked request
// that outranks everything in service, runs the two-pulse INTA handshake,
// drives the vector byte on the second pulse and maintains the ISR / EOI logic.
// Ports: clk, reset (sync, active-high); Int_Req_Reg, Int_Mask_Reg, Vector_Base,
//        Auto_EOI, INTA_n, Non_Specific_EOI, Specific_EOI, EOI_Level (inputs);
//        INT, Clear_bits_IRR, In_Service_Reg, Vector_Out, Vector_Valid (registered outputs).
module interrupt_ack_sequencer
  import pic_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] Int_Req_Reg,
  input  logic [NUM_LEVELS-1:0] Int_Mask_Reg,
  input  logic [VBASE_W-1:0]    Vector_Base,
  input  logic                  Auto_EOI,
  input  logic                  INTA_n,
  input  logic                  Non_Specific_EOI,
  input  logic                  Specific_EOI,
  input  logic [LEVEL_W-1:0]    EOI_Level,
  output logic                  INT,
  output logic [NUM_LEVELS-1:0] Clear_bits_IRR,
  output logic [NUM_LEVELS-1:0] In_Service_Reg,
  output logic [7:0]            Vector_Out,
  output logic                  Vector_Valid
);

  state_e                r_state;
  logic                  r_inta_q;
  logic [LEVEL_W-1:0]    r_level;
  logic                  r_spurious;
  logic                  r_int;
  logic [NUM_LEVELS-1:0] r_clr;
  logic [NUM_LEVELS-1:0] r_isr;
  logic [7:0]            r_vec;
  logic                  r_vvalid;

  state_e                w_state_nxt;
  logic [LEVEL_W-1:0]    w_level_nxt;
  logic                  w_spurious_nxt;
  logic                  w_int_nxt;
  logic [NUM_LEVELS-1:0] w_clr_nxt;
  logic [NUM_LEVELS-1:0] w_isr_set;
  logic [NUM_LEVELS-1:0] w_isr_clr;
  logic [NUM_LEVELS-1:0] w_isr_nxt;
  logic [7:0]            w_vec_nxt;
  logic                  w_vvalid_nxt;

  logic [NUM_LEVELS-1:0] w_pending;
  logic [LEVEL_W-1:0]    w_pend_idx;
  logic                  w_pend_valid;
  logic [LEVEL_W-1:0]    w_isr_idx;
  logic                  w_isr_valid;
  logic                  w_qualified;
  logic                  w_fall;
  logic                  w_rise;

  assign w_pending = Int_Req_Reg & ~Int_Mask_Reg;

  Priority_Resolver u_pend_res (
    .i_vec     (w_pending),
    .o_idx_c   (w_pend_idx),
    .o_valid_c (w_pend_valid)
  );

  Priority_Resolver u_isr_res (
    .i_vec     (r_isr),
    .o_idx_c   (w_isr_idx),
    .o_valid_c (w_isr_valid)
  );

  // A candidate only interrupts if it outranks the highest level in service.
  assign w_qualified = w_pend_valid && (!w_isr_valid || (w_pend_idx < w_isr_idx));
  assign w_fall      = r_inta_q & ~INTA_n;
  assign w_rise      = ~r_inta_q & INTA_n;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_spurious_nxt = r_spurious;
    w_int_nxt      = r_int;
    w_clr_nxt      = '0;
    w_isr_set      = '0;
    w_isr_clr      = '0;
    w_vec_nxt      = r_vec;
    w_vvalid_nxt   = r_vvalid;

    unique case (r_state)
      ST_IDLE: begin
        if (w_qualified) begin
          w_int_nxt   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_fall) begin
          // Request withdrawn since INT was raised: answer with the spurious level.
          w_spurious_nxt = ~w_pend_valid;
          w_level_nxt    = w_pend_valid ? w_pend_idx : SPURIOUS_LEVEL;
          if (w_pend_valid) begin
            w_isr_set = level_onehot(w_pend_idx);
            w_clr_nxt = level_onehot(w_pend_idx);
          end
          w_int_nxt   = 1'b0;
          w_state_nxt = ST_ACK1;
        end
      end
      ST_ACK1: begin
        if (w_rise) w_state_nxt = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (w_fall) begin
          w_vec_nxt    = {Vector_Base, r_level};
          w_vvalid_nxt = 1'b1;
          w_state_nxt  = ST_ACK2;
        end
      end
      ST_ACK2: begin
        if (w_rise) begin
          w_vvalid_nxt = 1'b0;
          if (Auto_EOI && !r_spurious) w_isr_clr = level_onehot(r_level);
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // EOI commands apply in every state; specific outranks non-specific.
    if (Specific_EOI) begin
      w_isr_clr = w_isr_clr | level_onehot(EOI_Level);
    end else if (Non_Specific_EOI && w_isr_valid) begin
      w_isr_clr = w_isr_clr | level_onehot(w_isr_idx);
    end

    w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_inta_q   <= 1'b1;
      r_level    <= '0;
      r_spurious <= 1'b0;
      r_int      <= 1'b0;
      r_clr      <= '0;
      r_isr      <= '0;
      r_vec      <= '0;
      r_vvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inta_q   <= INTA_n;
      r_level    <= w_level_nxt;
      r_spurious <= w_spurious_nxt;
      r_int      <= w_int_nxt;
      r_clr      <= w_clr_nxt;
      r_isr      <= w_isr_nxt;
      r_vec      <= w_vec_nxt;
      r_vvalid   <= w_vvalid_nxt;
    end
  end

  assign INT            = r_int;
  assign Clear_bits_IRR = r_clr;
  assign In_Service_Reg = r_isr;
  assign Vector_Out     = r_vec;
  assign Vector_Valid   = r_vvalid;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: a behavioural model tracks
// handshake progress as a step count and is compared every cycle, directed
// scenarios pin the model with literal values, then randomized traffic runs.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Int_Req_Reg, Int_Mask_Reg;
  logic [4:0] Vector_Base;
  logic       Auto_EOI, INTA_n, Non_Specific_EOI, Specific_EOI;
  logic [2:0] EOI_Level;
  logic       INT, Vector_Valid;
  logic [7:0] Clear_bits_IRR, In_Service_Reg, Vector_Out;

  int total = 0;
  int bad   = 0;

  interrupt_ack_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .Int_Req_Reg      (Int_Req_Reg),
    .Int_Mask_Reg     (Int_Mask_Reg),
    .Vector_Base      (Vector_Base),
    .Auto_EOI         (Auto_EOI),
    .INTA_n           (INTA_n),
    .Non_Specific_EOI (Non_Specific_EOI),
    .Specific_EOI     (Specific_EOI),
    .EOI_Level        (EOI_Level),
    .INT              (INT),
    .Clear_bits_IRR   (Clear_bits_IRR),
    .In_Service_Reg   (In_Service_Reg),
    .Vector_Out       (Vector_Out),
    .Vector_Valid     (Vector_Valid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // step: 0 idle, 1 INT raised, 2 first pulse low, 3 between pulses, 4 vector driven
  int         m_step;
  int         m_level;
  bit         m_spur;
  bit         m_prev;
  bit         m_live = 0;
  logic       e_int, e_vv;
  logic [7:0] e_clr, e_isr, e_vec;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int lp, li;
    bit fall, rise;
    logic [7:0] clr, set;
    if (reset) begin
      m_step = 0; m_level = 0; m_spur = 0; m_prev = 1;
      e_int = 0; e_vv = 0; e_clr = 0; e_isr = 0; e_vec = 0;
      m_live = 1;
    end else if (m_live) begin
      fall = m_prev && !INTA_n;
      rise = !m_prev && INTA_n;
      lp = lowest(Int_Req_Reg & ~Int_Mask_Reg);
      li = lowest(e_isr);
      clr = 0; set = 0; e_clr = 0;
      case (m_step)
        0: if (lp >= 0 && (li < 0 || lp < li)) begin e_int = 1; m_step = 1; end
        1: if (fall) begin
             m_spur  = (lp < 0);
             m_level = m_spur ? 7 : lp;
             if (!m_spur) begin set = 8'd1 << m_level; e_clr = set; end
             e_int = 0; m_step = 2;
           end
        2: if (rise) m_step = 3;
        3: if (fall) begin e_vec = Vector_Base * 8 + m_level; e_vv = 1; m_step = 4; end
        default: if (rise) begin
             e_vv = 0;
             if (Auto_EOI && !m_spur) clr = 8'd1 << m_level;
             m_step = 0;
           end
      endcase
      if (Specific_EOI) clr = clr | (8'd1 << EOI_Level);
      else if (Non_Specific_EOI && li >= 0) clr = clr | (8'd1 << li);
      e_isr = (e_isr & ~clr) | set;
      m_prev = INTA_n;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Compare process: every cycle once the model has seen reset.
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("INT",            {7'd0, INT},          {7'd0, e_int});
      chk("Clear_bits_IRR", Clear_bits_IRR,       e_clr);
      chk("In_Service_Reg", In_Service_Reg,       e_isr);
      chk("Vector_Out",     Vector_Out,           e_vec);
      chk("Vector_Valid",   {7'd0, Vector_Valid}, {7'd0, e_vv});
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] cap_clr, cap_isr1, cap_vec, cap_isr_vv, cap_isr2;
  logic       cap_int, cap_vv, cap_vv_after;

  task automatic wait_int(input string nm);
    int n = 0;
    while (INT !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (INT !== 1'b1) begin
      bad++;
      $display("FAIL %s: INT timeout, got %b expected 1", nm, INT);
    end
  endtask

  // Full two-pulse handshake; upstream IRR clear is emulated from Clear_bits_IRR.
  task automatic do_inta();
    INTA_n = 0; @(negedge clk);
    cap_clr = Clear_bits_IRR; cap_isr1 = In_Service_Reg; cap_int = INT;
    Int_Req_Reg = Int_Req_Reg & ~Clear_bits_IRR;
    INTA_n = 1; @(negedge clk);
    @(negedge clk);
    INTA_n = 0; @(negedge clk);
    cap_vv = Vector_Valid; cap_vec = Vector_Out; cap_isr_vv = In_Service_Reg;
    INTA_n = 1; @(negedge clk);
    cap_vv_after = Vector_Valid; cap_isr2 = In_Service_Reg;
  endtask

  task automatic pulse_eoi(input bit spec, input bit ns, input logic [2:0] lvl);
    Specific_EOI = spec; Non_Specific_EOI = ns; EOI_Level = lvl;
    @(negedge clk);
    Specific_EOI = 0; Non_Specific_EOI = 0;
  endtask

  initial begin
    int cnt;
    reset = 1; Int_Req_Reg = 0; Int_Mask_Reg = 0; Vector_Base = 5'h08;
    Auto_EOI = 0; INTA_n = 1; Non_Specific_EOI = 0; Specific_EOI = 0; EOI_Level = 0;
    repeat (3) @(negedge clk);
    chk("reset_int", {7'd0, INT}, 8'd0);
    chk("reset_isr", In_Service_Reg, 8'h00);
    reset = 0;
    @(negedge clk);

    // Basic handshake, level 4.
    Int_Req_Reg = 8'h10;
    wait_int("basic");
    do_inta();
    chk("basic_clr", cap_clr, 8'h10);
    chk("basic_isr", cap_isr1, 8'h10);
    chk("basic_int_low", {7'd0, cap_int}, 8'd0);
    chk("basic_vv", {7'd0, cap_vv}, 8'd1);
    chk("basic_vec", cap_vec, 8'h44);
    chk("basic_vv_fall", {7'd0, cap_vv_after}, 8'd0);
    chk("basic_clr_1cyc", Clear_bits_IRR, 8'h00);
    pulse_eoi(1, 0, 3'd4);
    chk("basic_eoi", In_Service_Reg, 8'h00);

    // Masked level 0, level 7 serviced, then non-specific EOI.
    Int_Req_Reg = 8'h81; Int_Mask_Reg = 8'h01;
    wait_int("mask");
    do_inta();
    chk("mask_vec", cap_vec, 8'h47);
    chk("mask_isr", cap_isr2, 8'h80);
    Int_Req_Reg = 0; Int_Mask_Reg = 0;
    pulse_eoi(0, 1, 3'd0);
    chk("ns_eoi", In_Service_Reg, 8'h00);

    // Nesting: ISR=04 blocks level 5, admits level 1.
    Int_Req_Reg = 8'h04;
    wait_int("nest_a");
    do_inta();
    chk("nest_isr_a", cap_isr2, 8'h04);
    Int_Req_Reg = 8'h20;
    repeat (4) @(negedge clk);
    chk("nest_blocked", {7'd0, INT}, 8'd0);
    Int_Req_Reg = 8'h22;
    wait_int("nest_b");
    do_inta();
    chk("nest_isr_b", cap_isr1, 8'h06);
    Int_Req_Reg = 0;
    pulse_eoi(1, 1, 3'd1);
    pulse_eoi(0, 1, 3'd0);
    chk("nest_cleanup", In_Service_Reg, 8'h00);

    // Spurious: request withdrawn after INT.
    Int_Req_Reg = 8'h08;
    wait_int("spur");
    Int_Req_Reg = 0;
    do_inta();
    chk("spur_clr", cap_clr, 8'h00);
    chk("spur_isr", cap_isr1, 8'h00);
    chk("spur_vec", cap_vec, 8'h47);

    // Auto-EOI on level 0.
    Auto_EOI = 1; Int_Req_Reg = 8'h01;
    wait_int("aeoi");
    do_inta();
    chk("aeoi_isr_ack1", cap_isr1, 8'h01);
    chk("aeoi_isr_ack2", cap_isr_vv, 8'h01);
    chk("aeoi_isr_done", cap_isr2, 8'h00);
    chk("aeoi_vv_done", {7'd0, cap_vv_after}, 8'd0);
    Auto_EOI = 0;

    // Reset in WAIT2, then a stray INTA pulse must be ignored.
    Int_Req_Reg = 8'h10;
    wait_int("rst");
    INTA_n = 0; @(negedge clk);
    Int_Req_Reg = 0; INTA_n = 1; @(negedge clk);
    reset = 1; @(negedge clk);
    chk("rst_isr", In_Service_Reg, 8'h00);
    chk("rst_vec", Vector_Out, 8'h00);
    chk("rst_int", {7'd0, INT}, 8'd0);
    reset = 0;
    INTA_n = 0; @(negedge clk);
    INTA_n = 1; @(negedge clk);
    @(negedge clk);
    chk("rst_ignored_vv", {7'd0, Vector_Valid}, 8'd0);
    chk("rst_ignored_isr", In_Service_Reg, 8'h00);

    // Randomized traffic against the model.
    cnt = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) Int_Req_Reg = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 63) == 0) Int_Mask_Reg = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        Auto_EOI = 1'($urandom); Vector_Base = 5'($urandom);
      end
      if ($urandom_range(0, 299) == 0) reset = 1; else reset = 0;
      Specific_EOI     = ($urandom_range(0, 11) == 0);
      Non_Specific_EOI = ($urandom_range(0, 9) == 0);
      EOI_Level        = 3'($urandom);
      cnt--;
      if (cnt == 0) begin INTA_n = ~INTA_n; cnt = $urandom_range(1, 4); end
      @(negedge clk);
    end
    reset = 0; Specific_EOI = 0; Non_Specific_EOI = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
